// File: rtl/rock_pkg.sv
// Shared definitions for the cradle rocking controller: state encoding,
// level and heart-rate widths, and a saturating level increment helper.
package rock_pkg;

    localparam int HART_W  = 6;
    localparam int LEVEL_W = 2;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd3;

    // Strobes spent in WARMUP before monitoring starts.
    localparam int WARMUP_STROBES = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MONITOR = 3'd2,
        ST_RAMP    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DOWN    = 3'd5,
        ST_ALARM   = 3'd6
    } rock_state_e;

    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + 1'b1;
    endfunction

endpackage

// File: rtl/sample_ticker.sv
// Sample prescaler: counts 0..SAMPLE_DIV-1 and flags the last count as the
// one-cycle sample strobe that advances the heart-rate delay chain.
module sample_ticker #(
    parameter int SAMPLE_DIV = 16
) (
    input  logic slow,
    input  logic reset,
    output logic sample_en
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running wrap-around prescaler.
    always_ff @(posedge slow or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Decoded from the counter register only, so the strobe is glitch-free
    // and has no path from the controller inputs.
    assign sample_en = (count == LAST);

endmodule

// File: rtl/rock_stress_controller.sv
// Cradle rocking controller: classifies each heart-rate sample as stress,
// calm or neutral and steps the rocking level up/hold/down accordingly.
// Optional feature macro: ROCK_WATCHDOG_EN adds a max-level watchdog that
// latches a sticky alarm and parks the FSM in ALARM until reset.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | just out of reset, waiting for the first strobe
//  WARMUP  | letting the delay chain fill, stability ignored
//  MONITOR | level 0, counting consecutive stressed samples
//  RAMP    | raising level on stress, calm sample moves to HOLD
//  HOLD    | keeping level, counting consecutive calm samples
//  DOWN    | lowering level on calm samples until 0
//  ALARM   | watchdog tripped, level 0, left only by reset
module rock_stress_controller
    import rock_pkg::*;
#(
    parameter int                SAMPLE_DIV       = 16,
    parameter logic [HART_W-1:0] HART_HI          = 6'd40,
    parameter int                STRESS_SAMPLES   = 3,
    parameter int                HOLD_SAMPLES     = 8,
    parameter int                MAX_ROCK_SAMPLES = 32
) (
    input  logic               slow,
    input  logic               reset,
    input  logic [HART_W-1:0]  hart,
    input  logic               stable,
    output logic               sample_en,
    output logic [LEVEL_W-1:0] rock_level,
    output logic               rock_on,
    output logic [2:0]         state,
    output logic               alarm
);

    localparam int STRESS_W = $clog2(STRESS_SAMPLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_SAMPLES + 1);
    localparam int WARM_W   = $clog2(WARMUP_STROBES + 1);

    // Counters hold "samples seen so far", so the deciding sample is the
    // one arriving when the count already equals N-1.
    localparam logic [STRESS_W-1:0] STRESS_LAST = STRESS_W'(STRESS_SAMPLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [WARM_W-1:0]   WARM_LAST   = WARM_W'(WARMUP_STROBES - 1);

    rock_state_e         state_q, state_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [STRESS_W-1:0] stress_cnt, stress_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_d;
    logic [WARM_W-1:0]   warm_cnt, warm_d;
    logic                rock_on_q;
    logic                is_stress, is_calm;

    sample_ticker #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_ticker (
        .slow      (slow),
        .reset     (reset),
        .sample_en (sample_en)
    );

    assign is_stress = (hart >= HART_HI);
    assign is_calm   = !is_stress && stable;

`ifdef ROCK_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_ROCK_SAMPLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_ROCK_SAMPLES - 1);

    logic [WD_W-1:0] wd_cnt, wd_d;
    logic            alarm_q, alarm_d;
`endif

    // Next-state, level and counter decisions, taken only on sample strobes.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        stress_d = stress_cnt;
        hold_d   = hold_cnt;
        warm_d   = warm_cnt;
`ifdef ROCK_WATCHDOG_EN
        wd_d     = wd_cnt;
        alarm_d  = alarm_q;
`endif
        if (sample_en) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                end
                ST_WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state_d  = ST_MONITOR;
                        stress_d = '0;
                    end else begin
                        warm_d = warm_cnt + 1'b1;
                    end
                end
                ST_MONITOR: begin
                    level_d = '0;
                    if (is_stress) begin
                        if (stress_cnt == STRESS_LAST) begin
                            state_d  = ST_RAMP;
                            level_d  = LEVEL_W'(1);
                            stress_d = '0;
                        end else begin
                            stress_d = stress_cnt + 1'b1;
                        end
                    end else begin
                        stress_d = '0;
                    end
                end
                ST_RAMP: begin
                    if (is_stress) begin
                        level_d = level_inc(level_q);
                    end else if (is_calm) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
                ST_HOLD: begin
                    if (is_stress) begin
                        state_d = ST_RAMP;
                        level_d = level_inc(level_q);
                    end else if (is_calm) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_d = ST_DOWN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                ST_DOWN: begin
                    if (is_stress) begin
                        state_d = ST_RAMP;
                        level_d = level_inc(level_q);
                    end else if (is_calm) begin
                        if (level_q != '0) begin
                            level_d = level_q - 1'b1;
                        end
                        if (level_q <= LEVEL_W'(1)) begin
                            state_d  = ST_MONITOR;
                            stress_d = '0;
                        end
                    end
                end
`ifdef ROCK_WATCHDOG_EN
                ST_ALARM: begin
                    level_d = '0;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
`ifdef ROCK_WATCHDOG_EN
            // Watchdog looks at the level being held going into this strobe
            // and overrides the normal transition when it trips.
            if ((state_q == ST_RAMP || state_q == ST_HOLD) && level_q == LEVEL_MAX) begin
                if (wd_cnt == WD_LAST) begin
                    alarm_d = 1'b1;
                    state_d = ST_ALARM;
                    level_d = '0;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_cnt + 1'b1;
                end
            end else begin
                wd_d = '0;
            end
`endif
        end
    end

    // State, level and counter registers.
    always_ff @(posedge slow or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            stress_cnt <= '0;
            hold_cnt   <= '0;
            warm_cnt   <= '0;
            rock_on_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            stress_cnt <= stress_d;
            hold_cnt   <= hold_d;
            warm_cnt   <= warm_d;
            rock_on_q  <= (level_d != '0);
        end
    end

`ifdef ROCK_WATCHDOG_EN
    // Watchdog counter and sticky alarm.
    always_ff @(posedge slow or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            alarm_q <= 1'b0;
        end else begin
            wd_cnt  <= wd_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    assign state      = state_q;
    assign rock_level = level_q;
    assign rock_on    = rock_on_q;

endmodule
